// File: rtl/sc_core_oz_wb.sv
// Write-back stage: selects ALU / PC+4 / aligned load data and drives the register-file write port.
// Loads park the FSM in WAIT_LOAD (wb_ready low) until a response or timeout; all outputs are registered.
module sc_core_oz_wb #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_reg_wr_en,
  input  logic [1:0]  ex_wb_sel,
  input  logic [4:0]  ex_rd_addr,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_pc_plus4,
  input  logic [2:0]  ex_funct3,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        wb_ready,
  output logic        rd_reg_wr_en,
  output logic [4:0]  rd_reg_address,
  output logic [31:0] rd_reg_data,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic        err_spurious,
  output logic [31:0] retire_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT_LOAD = 1'b1} state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_we_q, ld_we_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_mis_q, err_mis_d;
  logic        err_tmo_q, err_tmo_d;
  logic        err_spur_q, err_spur_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic [31:0] ld_shifted;
  logic [31:0] ld_value;
  logic        ld_legal;
  logic        accept;

  assign wb_ready = (state_q == S_IDLE);
  assign accept   = ex_valid && wb_ready;

  // Shift the addressed byte/halfword down to bit 0, then extend per funct3.
  always_comb begin
    ld_shifted = dmem_rsp_data >> {ld_lo_q, 3'b000};
    ld_value   = ld_shifted;
    ld_legal   = 1'b0;
    case (ld_f3_q)
      3'b000: begin ld_legal = 1'b1;            ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};   end
      3'b100: begin ld_legal = 1'b1;            ld_value = {24'd0, ld_shifted[7:0]};                 end
      3'b001: begin ld_legal = !ld_lo_q[0];     ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]}; end
      3'b101: begin ld_legal = !ld_lo_q[0];     ld_value = {16'd0, ld_shifted[15:0]};                end
      3'b010: begin ld_legal = (ld_lo_q == 2'b00); ld_value = ld_shifted;                            end
      default: begin ld_legal = 1'b0;           ld_value = ld_shifted;                               end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_mis_d  = 1'b0;
    err_tmo_d  = 1'b0;
    err_spur_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_spur_d = dmem_rsp_valid;
        if (accept) begin
          case (ex_wb_sel)
            SEL_ALU, SEL_PC4: begin
              if (ex_reg_wr_en && (ex_rd_addr != 5'd0)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ex_rd_addr;
                wr_data_d = (ex_wb_sel == SEL_ALU) ? ex_alu_result : ex_pc_plus4;
              end
            end
            SEL_LOAD: begin
              // Entered even for rd=0 / no write so the response is still consumed.
              ld_rd_d   = ex_rd_addr;
              ld_we_d   = ex_reg_wr_en;
              ld_f3_d   = ex_funct3;
              ld_lo_d   = ex_alu_result[1:0];
              tmo_cnt_d = 32'd0;
              state_d   = S_WAIT_LOAD;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_LOAD: begin
        if (dmem_rsp_valid) begin
          state_d = S_IDLE;
          if (!ld_legal) begin
            err_mis_d = 1'b1;
          end else if (ld_we_q && (ld_rd_q != 5'd0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ld_rd_q;
            wr_data_d = ld_value;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
          if ((LOAD_TIMEOUT != 0) && (tmo_cnt_d == 32'(LOAD_TIMEOUT))) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    retire_cnt_d = retire_cnt_q + {31'd0, wr_en_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tmo_cnt_q    <= 32'd0;
      ld_rd_q      <= 5'd0;
      ld_we_q      <= 1'b0;
      ld_f3_q      <= 3'd0;
      ld_lo_q      <= 2'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= 32'd0;
      err_mis_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      err_spur_q   <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ld_rd_q      <= ld_rd_d;
      ld_we_q      <= ld_we_d;
      ld_f3_q      <= ld_f3_d;
      ld_lo_q      <= ld_lo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_mis_q    <= err_mis_d;
      err_tmo_q    <= err_tmo_d;
      err_spur_q   <= err_spur_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign rd_reg_wr_en   = wr_en_q;
  assign rd_reg_address = wr_addr_q;
  assign rd_reg_data    = wr_data_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_tmo_q;
  assign err_spurious   = err_spur_q;
  assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_sc_core_oz_wb.sv
// Bench for sc_core_oz_wb: directed steps then random retire/load traffic against a behavioural model.
module tb_sc_core_oz_wb;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_wr_en;
  logic [1:0]  ex_wb_sel;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_alu_result, ex_pc_plus4;
  logic [2:0]  ex_funct3;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        wb_ready, rd_reg_wr_en, err_misaligned, err_timeout, err_spurious;
  logic [4:0]  rd_reg_address;
  logic [31:0] rd_reg_data, retire_cnt;

  int checks = 0;
  int failures = 0;

  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_cnt  = '0;

  int          r;
  logic [4:0]  rrd;

  sc_core_oz_wb #(.LOAD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_wr_en(ex_reg_wr_en),
    .ex_wb_sel(ex_wb_sel), .ex_rd_addr(ex_rd_addr), .ex_alu_result(ex_alu_result),
    .ex_pc_plus4(ex_pc_plus4), .ex_funct3(ex_funct3), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data), .wb_ready(wb_ready), .rd_reg_wr_en(rd_reg_wr_en),
    .rd_reg_address(rd_reg_address), .rd_reg_data(rd_reg_data),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout),
    .err_spurious(err_spurious), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input bit we, input bit mis, input bit tmo, input bit spur);
    chk({tag, "_wr_en"}, {31'd0, rd_reg_wr_en}, {31'd0, we});
    chk({tag, "_mis"},   {31'd0, err_misaligned}, {31'd0, mis});
    chk({tag, "_tmo"},   {31'd0, err_timeout}, {31'd0, tmo});
    chk({tag, "_spur"},  {31'd0, err_spurious}, {31'd0, spur});
    chk({tag, "_addr"},  {27'd0, rd_reg_address}, {27'd0, exp_addr});
    chk({tag, "_data"},  rd_reg_data, exp_data);
    chk({tag, "_cnt"},   retire_cnt, exp_cnt);
    chk({tag, "_rdy"},   {31'd0, wb_ready}, 32'd1);
  endtask

  // Load result from the ISA rules: access size, natural alignment, then extension by arithmetic.
  function automatic void model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d,
                                     output bit legal, output logic [31:0] v);
    int unsigned size, w;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7) && ((int'(lo) % size) == 0);
    w = d >> (8 * int'(lo));
    if (size == 1) begin
      w = w % 256;
      if (!f3[2] && w >= 128) w = w + 32'hFFFF_FF00;
    end else if (size == 2) begin
      w = w % 65536;
      if (!f3[2] && w >= 32768) w = w + 32'hFFFF_0000;
    end
    v = w;
  endfunction

  // One IDLE cycle: optional ALU/PC4/reserved instruction, optional stray response.
  task automatic issue(input string tag, input bit vld, input logic [1:0] sel, input bit we,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4, input bit spur);
    bit w;
    ex_valid = vld; ex_wb_sel = sel; ex_reg_wr_en = we; ex_rd_addr = rd;
    ex_alu_result = alu; ex_pc_plus4 = pc4; ex_funct3 = 3'($urandom);
    dmem_rsp_valid = spur; dmem_rsp_data = $urandom;
    @(posedge clk); #1;
    ex_valid = 1'b0; dmem_rsp_valid = 1'b0;
    w = vld && we && (rd != 5'd0) && (sel == 2'b00 || sel == 2'b10);
    if (w) begin
      exp_addr = rd;
      exp_data = (sel == 2'b00) ? alu : pc4;
      exp_cnt  = exp_cnt + 1;
    end
    chk_outputs(tag, w, 1'b0, 1'b0, spur);
  endtask

  // Load with the response dly cycles after acceptance (timeout if dly exceeds T).
  task automatic do_load(input string tag, input logic [4:0] rd, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input int dly, input logic [31:0] d);
    bit legal, tmo, w, mis;
    logic [31:0] v;
    int last;
    ex_valid = 1'b1; ex_wb_sel = 2'b01; ex_reg_wr_en = we; ex_rd_addr = rd;
    ex_alu_result = addr; ex_funct3 = f3; ex_pc_plus4 = $urandom;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    tmo  = (T != 0) && (dly > T);
    last = tmo ? T : dly;
    for (int k = 1; k <= last; k++) begin
      chk({tag, "_wait_rdy"}, {31'd0, wb_ready}, 32'd0);
      chk({tag, "_wait_wr"}, {31'd0, rd_reg_wr_en}, 32'd0);
      if (k == dly) begin
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = d;
      end
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_data  = $urandom;
    end
    model_load(f3, addr[1:0], d, legal, v);
    mis = !tmo && !legal;
    w   = !tmo && legal && we && (rd != 5'd0);
    if (w) begin
      exp_addr = rd;
      exp_data = v;
      exp_cnt  = exp_cnt + 1;
    end
    chk_outputs(tag, w, mis, tmo, 1'b0);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_reg_wr_en = 1'b0; ex_wb_sel = 2'b00; ex_rd_addr = '0;
    ex_alu_result = '0; ex_pc_plus4 = '0; ex_funct3 = '0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    #12;
    chk_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue("alu_rd5", 1'b1, 2'b00, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 1'b0);
    chk("alu_rd5_const", rd_reg_data, 32'h1234_5678);
    chk("alu_rd5_cnt1", retire_cnt, 32'd1);
    issue("alu_rd0", 1'b1, 2'b00, 1'b1, 5'd0, 32'h1234_5678, 32'h0, 1'b0);
    issue("pc4", 1'b1, 2'b10, 1'b1, 5'd1, 32'hDEAD_BEEF, 32'h0000_1004, 1'b0);
    issue("no_we", 1'b1, 2'b00, 1'b0, 5'd7, 32'hAAAA_5555, 32'h0, 1'b0);
    issue("rsvd", 1'b1, 2'b11, 1'b1, 5'd7, 32'hAAAA_5555, 32'h0, 1'b0);

    do_load("lb", 5'd9, 1'b1, 3'b000, 32'h0000_1002, 3, 32'h0080_0000);
    chk("lb_const", rd_reg_data, 32'hFFFF_FF80);
    do_load("lbu", 5'd9, 1'b1, 3'b100, 32'h0000_1002, 3, 32'h0080_0000);
    chk("lbu_const", rd_reg_data, 32'h0000_0080);
    do_load("lw_mis", 5'd3, 1'b1, 3'b010, 32'h0000_2001, 1, 32'h1111_2222);
    chk("lw_mis_flag", {31'd0, err_misaligned}, 32'd1);
    do_load("lh_mis", 5'd3, 1'b1, 3'b001, 32'h0000_2003, 2, 32'h1111_2222);
    do_load("lh_hi", 5'd4, 1'b1, 3'b001, 32'h0000_2002, 1, 32'h8001_0000);
    chk("lh_hi_const", rd_reg_data, 32'hFFFF_8001);
    do_load("ld_rd0", 5'd0, 1'b1, 3'b010, 32'h0000_2000, 2, 32'h5555_0000);
    do_load("tmo_edge", 5'd6, 1'b1, 3'b010, 32'h0000_3000, T, 32'hCAFE_F00D);
    do_load("timeout", 5'd6, 1'b1, 3'b010, 32'h0000_3000, T + 5, 32'h0);
    chk("timeout_flag", {31'd0, err_timeout}, 32'd1);
    issue("late_rsp", 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    chk("late_rsp_flag", {31'd0, err_spurious}, 32'd1);

    do_load("b2b_ld", 5'd10, 1'b1, 3'b010, 32'h0000_4000, 1, 32'h0BAD_CAFE);
    issue("b2b_alu", 1'b1, 2'b00, 1'b1, 5'd11, 32'h7777_8888, 32'h0, 1'b0);
    issue("spur_alu", 1'b1, 2'b00, 1'b1, 5'd12, 32'h0102_0304, 32'h0, 1'b1);

    ex_valid = 1'b1; ex_wb_sel = 2'b01; ex_reg_wr_en = 1'b1; ex_rd_addr = 5'd13;
    ex_alu_result = 32'h0000_5000; ex_funct3 = 3'b010;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("midrst_busy", {31'd0, wb_ready}, 32'd0);
    rst = 1'b0;
    #1;
    exp_addr = '0; exp_data = '0; exp_cnt = '0;
    chk_outputs("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    issue("midrst_rsp", 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);

    issue("pre_wrap", 1'b1, 2'b00, 1'b1, 5'd2, 32'h0000_0042, 32'h0, 1'b0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    issue("wrap", 1'b1, 2'b10, 1'b1, 5'd2, 32'h0, 32'h0000_2004, 1'b0);
    chk("wrap_zero", retire_cnt, 32'd0);

    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      rrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (r < 4) begin
        issue("rnd_ex", 1'b1, ($urandom_range(0, 3) == 0) ? 2'b11 : {1'($urandom), 1'b0},
              ($urandom_range(0, 5) != 0), rrd, $urandom, $urandom, ($urandom_range(0, 7) == 0));
      end else if (r < 8) begin
        do_load("rnd_ld", rrd, ($urandom_range(0, 5) != 0), 3'($urandom), $urandom,
                $urandom_range(1, T + 2), $urandom);
      end else begin
        issue("rnd_idle", 1'b0, 2'($urandom), 1'($urandom), rrd, $urandom, $urandom, 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
